// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD
    } fetch_state_t;
endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry holding register for a fetched instruction that decode could not take.
module fetch_skid_buf
    import fetch_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            clear,
    input  logic [XLEN-1:0] load_instr,
    input  logic [XLEN-1:0] load_pc,
    input  logic [XLEN-1:0] load_pcplus4,
    output logic            valid,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pcplus4
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid   <= 1'b0;
            instr   <= NOP_INSTR;
            pc      <= '0;
            pcplus4 <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid   <= 1'b1;
            instr   <= load_instr;
            pc      <= load_pc;
            pcplus4 <= load_pcplus4;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: next-PC selection, single-outstanding imem handshake,
// and the fetch-to-decode register backed by a one-entry skid buffer.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [XLEN-1:0] NOP_INSTR = fetch_pkg::NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall_d_i,
    input  logic            redirect_e_i,
    input  logic [XLEN-1:0] redirect_pc_e_i,
    input  logic            pred_taken_i,
    input  logic [XLEN-1:0] pred_target_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [XLEN-1:0] imem_rdata_i,
    output logic [XLEN-1:0] instr_d_o,
    output logic [XLEN-1:0] pc_d_o,
    output logic [XLEN-1:0] pcplus4_d_o,
    output logic            valid_d_o,
    output logic            flush_d_o
);

    localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(3));

    fetch_state_t    state_q, state_next;
    logic [XLEN-1:0] pc_q, pc_next;
    logic [XLEN-1:0] fpc_q, fpc_next;
    logic            kill_q, kill_next;

    logic [XLEN-1:0] redirect_pc, pred_pc, seq_pc, fpc_plus4;
    logic            slot_free, mem_load, skid_load, skid_clear, skid_move;
    logic            skid_valid;
    logic [XLEN-1:0] skid_instr, skid_pc, skid_pcplus4;

    assign redirect_pc = redirect_pc_e_i & ALIGN_MASK;
    assign pred_pc     = pred_target_i & ALIGN_MASK;
    assign seq_pc      = pc_q + XLEN'(4);
    assign fpc_plus4   = fpc_q + XLEN'(4);
    assign slot_free   = !valid_d_o || !stall_d_i;
    assign imem_addr_o = pc_q;
    assign flush_d_o   = redirect_e_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC & ALIGN_MASK;
            fpc_q   <= '0;
            kill_q  <= 1'b0;
        end else begin
            state_q <= state_next;
            pc_q    <= pc_next;
            fpc_q   <= fpc_next;
            kill_q  <= kill_next;
        end
    end

    always_comb begin
        state_next = state_q;
        pc_next    = pc_q;
        fpc_next   = fpc_q;
        kill_next  = kill_q;
        imem_req_o = 1'b0;
        mem_load   = 1'b0;
        skid_load  = 1'b0;
        skid_clear = 1'b0;
        skid_move  = 1'b0;
        case (state_q)
            IDLE: state_next = REQ;
            REQ: begin
                imem_req_o = 1'b1;
                if (imem_gnt_i) begin
                    fpc_next   = pc_q;
                    state_next = WAIT;
                    if (redirect_e_i) begin
                        kill_next = 1'b1;
                        pc_next   = redirect_pc;
                    end else begin
                        pc_next = pred_taken_i ? pred_pc : seq_pc;
                    end
                end else if (redirect_e_i) begin
                    pc_next = redirect_pc;
                end
            end
            WAIT: begin
                if (redirect_e_i) begin
                    pc_next = redirect_pc;
                    // A response landing with the redirect is consumed here, so nothing is left to kill.
                    if (imem_rvalid_i) begin
                        kill_next  = 1'b0;
                        state_next = REQ;
                    end else begin
                        kill_next = 1'b1;
                    end
                end else if (imem_rvalid_i) begin
                    state_next = REQ;
                    if (kill_q) begin
                        kill_next = 1'b0;
                    end else if (slot_free) begin
                        mem_load = 1'b1;
                    end else begin
                        skid_load  = 1'b1;
                        state_next = HOLD;
                    end
                end
            end
            HOLD: begin
                if (redirect_e_i) begin
                    skid_clear = 1'b1;
                    pc_next    = redirect_pc;
                    state_next = REQ;
                end else if (!stall_d_i) begin
                    skid_move  = skid_valid;
                    skid_clear = 1'b1;
                    state_next = REQ;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    fetch_skid_buf u_skid (
        .clk          (clk),
        .rst_n        (rst_n),
        .load         (skid_load),
        .clear        (skid_clear),
        .load_instr   (imem_rdata_i),
        .load_pc      (fpc_q),
        .load_pcplus4 (fpc_plus4),
        .valid        (skid_valid),
        .instr        (skid_instr),
        .pc           (skid_pc),
        .pcplus4      (skid_pcplus4)
    );

    // Redirect beats everything, then a stalled valid slot holds, then new data, then bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_d_o   <= 1'b0;
            instr_d_o   <= NOP_INSTR;
            pc_d_o      <= '0;
            pcplus4_d_o <= '0;
        end else if (redirect_e_i) begin
            valid_d_o <= 1'b0;
            instr_d_o <= NOP_INSTR;
        end else if (!(stall_d_i && valid_d_o)) begin
            if (mem_load) begin
                valid_d_o   <= 1'b1;
                instr_d_o   <= imem_rdata_i;
                pc_d_o      <= fpc_q;
                pcplus4_d_o <= fpc_plus4;
            end else if (skid_move) begin
                valid_d_o   <= 1'b1;
                instr_d_o   <= skid_instr;
                pc_d_o      <= skid_pc;
                pcplus4_d_o <= skid_pcplus4;
            end else if (!stall_d_i) begin
                valid_d_o <= 1'b0;
                instr_d_o <= NOP_INSTR;
            end
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed vector table, corner-case sequences,
// and a randomized run against a transaction-level fetch/delivery scoreboard.
module tb_fetch_ctrl;
    import fetch_pkg::*;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall_d_i, redirect_e_i, pred_taken_i;
    logic [31:0] redirect_pc_e_i, pred_target_i;
    logic        imem_req_o, imem_gnt_i, imem_rvalid_i;
    logic [31:0] imem_addr_o, imem_rdata_i;
    logic [31:0] instr_d_o, pc_d_o, pcplus4_d_o;
    logic        valid_d_o, flush_d_o;

    fetch_ctrl #(.RESET_PC(32'h0), .NOP_INSTR(NOP)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall_d_i       (stall_d_i),
        .redirect_e_i    (redirect_e_i),
        .redirect_pc_e_i (redirect_pc_e_i),
        .pred_taken_i    (pred_taken_i),
        .pred_target_i   (pred_target_i),
        .imem_req_o      (imem_req_o),
        .imem_addr_o     (imem_addr_o),
        .imem_gnt_i      (imem_gnt_i),
        .imem_rvalid_i   (imem_rvalid_i),
        .imem_rdata_i    (imem_rdata_i),
        .instr_d_o       (instr_d_o),
        .pc_d_o          (pc_d_o),
        .pcplus4_d_o     (pcplus4_d_o),
        .valid_d_o       (valid_d_o),
        .flush_d_o       (flush_d_o)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        logic        gnt, rvalid, pred, stall;
        logic [31:0] rdata, ptgt;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc, exp_instr;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    vec_t vecs[11];
    exp_t sb_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic gnt, input logic rv, input logic [31:0] rdata,
                                input logic pred, input logic [31:0] ptgt, input logic stall,
                                input logic ereq, input logic [31:0] eaddr, input logic evalid,
                                input logic [31:0] epc, input logic [31:0] einstr);
        vec_t v;
        v.gnt = gnt; v.rvalid = rv; v.rdata = rdata; v.pred = pred; v.ptgt = ptgt;
        v.stall = stall; v.exp_req = ereq; v.exp_addr = eaddr; v.exp_valid = evalid;
        v.exp_pc = epc; v.exp_instr = einstr;
        return v;
    endfunction

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return (a ^ 32'h5A5A_A5A5) + 32'h0000_00A0;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        stall_d_i = 0; redirect_e_i = 0; redirect_pc_e_i = 0; pred_taken_i = 0;
        pred_target_i = 0; imem_gnt_i = 0; imem_rvalid_i = 0; imem_rdata_i = 0;
    endtask

    // Leaves the bench at the start of the IDLE cycle right after reset release.
    task automatic do_reset();
        rst_n = 0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
    endtask

    // Called at the start of a REQ cycle: grant it, then return the response next cycle.
    task automatic seq_fetch(input logic [31:0] a);
        imem_gnt_i = 1;
        @(negedge clk);
        check("seq_req", imem_req_o, 1);
        check("seq_addr", imem_addr_o, a);
        cyc();
        imem_gnt_i = 0;
        imem_rvalid_i = 1;
        imem_rdata_i = 32'hA0 + a;
        @(negedge clk);
        cyc();
        imem_rvalid_i = 0;
    endtask

    initial begin
        logic [31:0] m_next_addr, pend_addr, mem_addr;
        logic        pend_live, mem_busy;
        int          mem_dly, delivered;

        // ---------------- reset values ----------------
        rst_n = 0;
        clear_inputs();
        #12;
        check("rst_valid", valid_d_o, 0);
        check("rst_instr", instr_d_o, NOP);
        check("rst_pc", pc_d_o, 0);
        check("rst_pcplus4", pcplus4_d_o, 0);
        check("rst_req", imem_req_o, 0);
        @(posedge clk);
        #1;
        rst_n = 1;

        // ---------------- vector table: sequential fetch and predicted taken ----------------
        vecs[0]  = mk(0, 0, 0,          0, 0,      0, 0, 0,     0, 0,     0);
        vecs[1]  = mk(1, 0, 0,          0, 0,      0, 1, 0,     0, 0,     0);
        vecs[2]  = mk(0, 1, 32'hA0,     0, 0,      0, 0, 0,     0, 0,     0);
        vecs[3]  = mk(1, 0, 0,          0, 0,      0, 1, 4,     1, 0,     32'hA0);
        vecs[4]  = mk(0, 1, 32'hA4,     0, 0,      0, 0, 0,     0, 0,     0);
        vecs[5]  = mk(1, 0, 0,          1, 32'h103,0, 1, 8,     1, 4,     32'hA4);
        vecs[6]  = mk(0, 1, 32'hA8,     0, 0,      0, 0, 0,     0, 0,     0);
        vecs[7]  = mk(0, 0, 0,          0, 0,      0, 1, 32'h100, 1, 8,   32'hA8);
        vecs[8]  = mk(1, 0, 0,          0, 0,      0, 1, 32'h100, 0, 0,   0);
        vecs[9]  = mk(0, 1, 32'h1A0,    0, 0,      0, 0, 0,     0, 0,     0);
        vecs[10] = mk(0, 0, 0,          0, 0,      0, 1, 32'h104, 1, 32'h100, 32'h1A0);
        for (int i = 0; i < 11; i++) begin
            imem_gnt_i = vecs[i].gnt; imem_rvalid_i = vecs[i].rvalid; imem_rdata_i = vecs[i].rdata;
            pred_taken_i = vecs[i].pred; pred_target_i = vecs[i].ptgt; stall_d_i = vecs[i].stall;
            @(negedge clk);
            check("vec_req", imem_req_o, vecs[i].exp_req);
            if (vecs[i].exp_req) check("vec_addr", imem_addr_o, vecs[i].exp_addr);
            check("vec_valid", valid_d_o, vecs[i].exp_valid);
            if (vecs[i].exp_valid) begin
                check("vec_pc", pc_d_o, vecs[i].exp_pc);
                check("vec_instr", instr_d_o, vecs[i].exp_instr);
                check("vec_pcplus4", pcplus4_d_o, vecs[i].exp_pc + 4);
            end
            $display("[TB] vec %0d req=%0b addr=%h valid=%0b pc=%h", i, imem_req_o, imem_addr_o, valid_d_o, pc_d_o);
            cyc();
        end

        // ---------------- redirect while waiting for addr 0xC ----------------
        do_reset();
        cyc();
        seq_fetch(0); seq_fetch(4); seq_fetch(8);
        imem_gnt_i = 1;
        @(negedge clk);
        check("rw_addr_c", imem_addr_o, 32'hC);
        cyc();
        imem_gnt_i = 0; redirect_e_i = 1; redirect_pc_e_i = 32'h200;
        @(negedge clk);
        check("rw_flush", flush_d_o, 1);
        cyc();
        redirect_e_i = 0; imem_rvalid_i = 1; imem_rdata_i = 32'hAC;
        cyc();
        imem_rvalid_i = 0; imem_gnt_i = 1;
        @(negedge clk);
        check("rw_req_addr", imem_addr_o, 32'h200);
        check("rw_dropped", valid_d_o, 0);
        cyc();
        imem_gnt_i = 0; imem_rvalid_i = 1; imem_rdata_i = 32'h2A0;
        cyc();
        imem_rvalid_i = 0;
        @(negedge clk);
        check("rw_valid", valid_d_o, 1);
        check("rw_pc", pc_d_o, 32'h200);
        check("rw_instr", instr_d_o, 32'h2A0);
        $display("[TB] redirect-in-wait done pc=%h", pc_d_o);

        // ---------------- grant and redirect in the same cycle ----------------
        do_reset();
        cyc();
        redirect_e_i = 1; redirect_pc_e_i = 32'h10;
        cyc();
        imem_gnt_i = 1; redirect_pc_e_i = 32'h300;
        @(negedge clk);
        check("gr_addr_10", imem_addr_o, 32'h10);
        check("gr_flush", flush_d_o, 1);
        cyc();
        imem_gnt_i = 0; redirect_e_i = 0; imem_rvalid_i = 1; imem_rdata_i = 32'hB0;
        cyc();
        imem_rvalid_i = 0; imem_gnt_i = 1;
        @(negedge clk);
        check("gr_req_addr", imem_addr_o, 32'h300);
        check("gr_dropped", valid_d_o, 0);
        cyc();
        imem_gnt_i = 0; imem_rvalid_i = 1; imem_rdata_i = 32'h3A0;
        cyc();
        imem_rvalid_i = 0;
        @(negedge clk);
        check("gr_pc", pc_d_o, 32'h300);
        check("gr_pcplus4", pcplus4_d_o, 32'h304);
        $display("[TB] grant+redirect done pc=%h", pc_d_o);

        // ---------------- stall with skid ----------------
        do_reset();
        cyc();
        seq_fetch(0); seq_fetch(4);
        imem_gnt_i = 1; stall_d_i = 1;
        @(negedge clk);
        check("sk_pc4", pc_d_o, 32'h4);
        check("sk_addr8", imem_addr_o, 32'h8);
        cyc();
        imem_gnt_i = 0; imem_rvalid_i = 1; imem_rdata_i = 32'hA8;
        cyc();
        imem_rvalid_i = 0;
        for (int i = 0; i < 3; i++) begin
            stall_d_i = (i < 2);
            @(negedge clk);
            check("sk_hold_req", imem_req_o, 0);
            check("sk_hold_pc", pc_d_o, 32'h4);
            check("sk_hold_valid", valid_d_o, 1);
            cyc();
        end
        @(negedge clk);
        check("sk_release_pc", pc_d_o, 32'h8);
        check("sk_release_instr", instr_d_o, 32'hA8);
        check("sk_next_addr", imem_addr_o, 32'hC);
        $display("[TB] skid done pc=%h", pc_d_o);

        // ---------------- PC wrap and asynchronous reset mid-WAIT ----------------
        do_reset();
        cyc();
        redirect_e_i = 1; redirect_pc_e_i = 32'hFFFF_FFFF;
        cyc();
        redirect_e_i = 0;
        seq_fetch(32'hFFFF_FFFC);
        imem_gnt_i = 1; stall_d_i = 1;
        @(negedge clk);
        check("wr_addr0", imem_addr_o, 0);
        check("wr_pc", pc_d_o, 32'hFFFF_FFFC);
        check("wr_pcplus4", pcplus4_d_o, 0);
        cyc();
        imem_gnt_i = 0;
        check("ar_pre_valid", valid_d_o, 1);
        #1 rst_n = 0;
        #1;
        check("ar_valid", valid_d_o, 0);
        check("ar_instr", instr_d_o, NOP);
        @(posedge clk);
        #1;
        rst_n = 1; stall_d_i = 0; imem_rvalid_i = 1; imem_rdata_i = 32'hDEAD_BEEF;
        cyc();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("ar_late_valid", valid_d_o, 0);
            check("ar_late_addr", imem_addr_o, 0);
            cyc();
            imem_rvalid_i = 0;
        end
        $display("[TB] wrap+async reset done");

        // ---------------- randomized run against the scoreboard ----------------
        do_reset();
        m_next_addr = 0; pend_live = 0; pend_addr = 0; mem_busy = 0; mem_addr = 0;
        mem_dly = 0; delivered = 0; sb_q.delete();
        for (int n = 0; n < 4000; n++) begin
            stall_d_i       = ($urandom_range(0, 99) < 30);
            redirect_e_i    = ($urandom_range(0, 99) < 6);
            redirect_pc_e_i = ($urandom_range(0, 9) == 0) ? (32'hFFFF_FFF8 | 32'($urandom_range(0, 7))) : $urandom;
            pred_taken_i    = ($urandom_range(0, 99) < 20);
            pred_target_i   = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFE : $urandom;
            imem_gnt_i      = ($urandom_range(0, 99) < 60);
            if (mem_busy && mem_dly == 0) begin
                imem_rvalid_i = 1;
                imem_rdata_i  = mem_data(mem_addr);
            end else begin
                imem_rvalid_i = 0;
                imem_rdata_i  = $urandom;
                if (mem_busy) mem_dly--;
            end
            @(negedge clk);
            check("rnd_flush", flush_d_o, redirect_e_i);
            if (imem_req_o) begin
                check("rnd_addr", imem_addr_o, m_next_addr);
                check("rnd_single_outstanding", mem_busy, 0);
            end
            if (valid_d_o) begin
                if (sb_q.size() == 0) begin
                    check("rnd_spurious_valid", valid_d_o, 0);
                end else begin
                    check("rnd_pc", pc_d_o, sb_q[0].pc);
                    check("rnd_instr", instr_d_o, sb_q[0].instr);
                    check("rnd_pcplus4", pcplus4_d_o, sb_q[0].pc + 4);
                end
            end
            // memory side
            if (imem_rvalid_i) mem_busy = 0;
            if (imem_req_o && imem_gnt_i) begin
                mem_busy = 1;
                mem_addr = imem_addr_o;
                mem_dly  = $urandom_range(0, 2);
            end
            // reference model: program-order delivery of live fetches
            if (valid_d_o && !stall_d_i && !redirect_e_i && sb_q.size() > 0) begin
                $display("[TB] rnd deliver pc=%h instr=%h", sb_q[0].pc, sb_q[0].instr);
                void'(sb_q.pop_front());
                delivered++;
            end
            if (imem_rvalid_i && pend_live) begin
                sb_q.push_back('{pc: pend_addr, instr: mem_data(pend_addr)});
                pend_live = 0;
            end
            if (imem_req_o && imem_gnt_i) begin
                pend_live = 1;
                pend_addr = m_next_addr;
                m_next_addr = pred_taken_i ? (pred_target_i & ~32'd3) : m_next_addr + 4;
            end
            if (redirect_e_i) begin
                sb_q.delete();
                pend_live = 0;
                m_next_addr = redirect_pc_e_i & ~32'd3;
            end
            cyc();
        end
        tests_run++;
        if (delivered < 100) begin
            tests_failed++;
            $display("FAIL rnd_progress: got %0d deliveries, expected at least 100", delivered);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
